// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and the hazard-decode predicate for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // True for every code the hazard unit must treat as an md-class instruction.
  function automatic logic mdu_is_md(input logic [3:0] op);
    return (op >= 4'(MDU_MULT)) && (op <= 4'(MDU_MSUBU));
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result datapath: next {hi,lo} for a latched mult/div op.
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0]      prod_s;
  logic [2*WIDTH-1:0]      prod_u;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic [WIDTH-1:0]        sq;
  logic [WIDTH-1:0]        sr;
  logic [WIDTH-1:0]        uq;
  logic [WIDTH-1:0]        ur;

  always_comb begin
    // Explicit sign extension keeps the signed product exact modulo 2^(2*WIDTH).
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sa     = $signed(a);
    sb     = $signed(b);
    sq     = '0;
    sr     = '0;
    uq     = '0;
    ur     = '0;
    if (b != '0) begin
      uq = a / b;
      ur = a % b;
      if ((a == SMIN) && (b == '1)) begin
        sq = SMIN;
        sr = '0;
      end else begin
        sq = WIDTH'(sa / sb);
        sr = WIDTH'(sa % sb);
      end
    end
  end

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
  assign acc = {hi, lo};
`endif

  always_comb begin
    {hi_n, lo_n} = {hi, lo};
    case (op)
      4'(MDU_MULT):  {hi_n, lo_n} = prod_s;
      4'(MDU_MULTU): {hi_n, lo_n} = prod_u;
      4'(MDU_DIV):   if (b != '0) {hi_n, lo_n} = {sr, sq};
      4'(MDU_DIVU):  if (b != '0) {hi_n, lo_n} = {ur, uq};
`ifdef MDU_MADD_EN
      4'(MDU_MADD):  {hi_n, lo_n} = acc + prod_s;
      4'(MDU_MADDU): {hi_n, lo_n} = acc + prod_u;
      4'(MDU_MSUB):  {hi_n, lo_n} = acc - prod_s;
      4'(MDU_MSUBU): {hi_n, lo_n} = acc - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers (E stage).
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise they behave as NOP.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             go_mul;
  logic             go_div;

  always_comb begin
    go_mul = 1'b0;
    go_div = 1'b0;
    case (op)
      4'(MDU_MULT), 4'(MDU_MULTU): go_mul = 1'b1;
`ifdef MDU_MADD_EN
      4'(MDU_MADD), 4'(MDU_MADDU),
      4'(MDU_MSUB), 4'(MDU_MSUBU): go_mul = 1'b1;
`endif
      4'(MDU_DIV), 4'(MDU_DIVU):   go_div = 1'b1;
      default: ;
    endcase
  end

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .hi   (hi),
    .lo   (lo),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (go_mul || go_div) begin
              op_q  <= op;
              a_q   <= srcA;
              b_q   <= srcB;
              cnt   <= go_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= ST_BUSY;
            end else if (op == 4'(MDU_MTHI)) begin
              hi <= srcA;
            end else if (op == 4'(MDU_MTLO)) begin
              lo <= srcA;
            end
          end
        end
        ST_BUSY: begin
          // Accumulate ops read hi/lo here, so the base is the value at completion.
          if (cnt == CW'(1)) begin
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
